// File: rtl/cim_collect_pkg.sv
// Shared defaults and FSM state encoding for the CIM bit-plane result collector.
package cim_collect_pkg;

    localparam int LANES_DEF  = 16;
    localparam int LANE_W_DEF = 12;
    localparam int NBITS_DEF  = 8;
    localparam int ACC_W_DEF  = LANE_W_DEF + NBITS_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/cim_lane_acc.sv
// One lane's shift-add accumulator for MSB-first bit planes.
// With CIM_SIGNED_MSB_EN defined the first plane carries negative weight (two's complement).
module cim_lane_acc #(
    parameter int LANE_W = 12,
    parameter int ACC_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              first,
    input  logic [LANE_W-1:0] lane,
    output logic [ACC_W-1:0]  acc
);

    logic [ACC_W-1:0] lane_ext;
    assign lane_ext = ACC_W'(lane);

    // The first plane overwrites whatever a previous operation left behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            if (first) begin
`ifdef CIM_SIGNED_MSB_EN
                acc <= '0 - lane_ext;
`else
                acc <= lane_ext;
`endif
            end else begin
                acc <= {acc[ACC_W-2:0], 1'b0} + lane_ext;
            end
        end
    end

endmodule

// File: rtl/cim_result_collector.sv
// Collects NBITS bit-plane results per lane into ACC_W-wide sums and holds them for the consumer.
// Optional build macro CIM_SIGNED_MSB_EN selects two's-complement (negative-weight MSB plane) accumulation.
module cim_result_collector
    import cim_collect_pkg::*;
#(
    parameter  int LANES  = LANES_DEF,
    parameter  int LANE_W = LANE_W_DEF,
    parameter  int NBITS  = NBITS_DEF,
    localparam int ACC_W  = LANE_W + NBITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     q_valid,
    input  logic [LANES*LANE_W-1:0]  q_in,
    output logic                     q_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*ACC_W-1:0]   out_data,
    output logic                     busy
);

    localparam int CNT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBITS - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             first;

    assign accept = q_valid && q_ready;
    assign first  = (cnt == '0);

    // q_ready, out_valid and busy are registered alongside the state so they never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            q_ready   <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        busy <= 1'b1;
                        if (cnt == CNT_LAST) begin
                            state     <= HOLD;
                            cnt       <= '0;
                            q_ready   <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                            cnt   <= cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        q_ready   <= 1'b1;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    q_ready   <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        cim_lane_acc #(
            .LANE_W (LANE_W),
            .ACC_W  (ACC_W)
        ) u_acc (
            .clk   (clk),
            .rst   (rst),
            .en    (accept),
            .first (first),
            .lane  (q_in[i*LANE_W +: LANE_W]),
            .acc   (out_data[i*ACC_W +: ACC_W])
        );
    end

endmodule

// File: tb/tb_cim_result_collector.sv
// Directed table-driven bench for cim_result_collector; expectations follow CIM_SIGNED_MSB_EN if defined.
module tb_cim_result_collector;

    localparam int LANES  = 16;
    localparam int LANE_W = 12;
    localparam int NBITS  = 8;
    localparam int ACC_W  = LANE_W + NBITS;
`ifdef CIM_SIGNED_MSB_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    q_valid;
    logic [LANES*LANE_W-1:0] q_in;
    logic                    q_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*ACC_W-1:0]  out_data;
    logic                    busy;

    int checks = 0;
    int errors = 0;

    logic [LANE_W-1:0] cur_planes [NBITS][LANES];
    logic [ACC_W-1:0]  exp_lane   [LANES];

    typedef struct {
        string               name;
        logic [7:0][11:0]    pl;
        logic [19:0]         exp_u;
        logic [19:0]         exp_s;
        int                  gap;
    } vec_t;

    vec_t vecs [9];

    cim_result_collector #(
        .LANES  (LANES),
        .LANE_W (LANE_W),
        .NBITS  (NBITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .q_valid   (q_valid),
        .q_in      (q_in),
        .q_ready   (q_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkv(string n, int p0, int p1, int p2, int p3, int p4, int p5, int p6, int p7,
                                 logic [19:0] eu, logic [19:0] es, int g);
        vec_t v;
        v.name  = n;
        v.pl[0] = 12'(p0); v.pl[1] = 12'(p1); v.pl[2] = 12'(p2); v.pl[3] = 12'(p3);
        v.pl[4] = 12'(p4); v.pl[5] = 12'(p5); v.pl[6] = 12'(p6); v.pl[7] = 12'(p7);
        v.exp_u = eu;
        v.exp_s = es;
        v.gap   = g;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string name);
        int bad = -1;
        for (int i = 0; i < LANES; i++)
            if (bad < 0 && out_data[i*ACC_W +: ACC_W] !== exp_lane[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("[TB] FAIL %s lane %0d: got 0x%05h expected 0x%05h",
                     name, bad, out_data[bad*ACC_W +: ACC_W], exp_lane[bad]);
        end
    endtask

    // Drives planes start..NBITS-1 from cur_planes, with optional idle gaps, then expects HOLD next cycle.
    task automatic applyStimulus(input string name, input int start, input int gap_mode);
        for (int p = start; p < NBITS; p++) begin
            int gap = (gap_mode < 0) ? (p % 4) : gap_mode;
            for (int g = 0; g < gap; g++) begin
                q_valid = 1'b0;
                @(posedge clk); #1;
            end
            checkVal({name, " q_ready"}, 32'(q_ready), 32'd1);
            q_valid = 1'b1;
            for (int i = 0; i < LANES; i++) q_in[i*LANE_W +: LANE_W] = cur_planes[p][i];
            @(posedge clk); #1;
        end
        q_valid = 1'b0;
        checkVal({name, " out_valid"}, 32'(out_valid), 32'd1);
        checkOutput({name, " data"});
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkVal({name, " drained"}, {30'd0, out_valid, q_ready}, 32'd1);
    endtask

    task automatic loadUniform(input vec_t v);
        for (int p = 0; p < NBITS; p++)
            for (int i = 0; i < LANES; i++) cur_planes[p][i] = v.pl[p];
        for (int i = 0; i < LANES; i++) exp_lane[i] = SIGNED_BUILD ? v.exp_s : v.exp_u;
    endtask

    initial begin
        rst = 1'b1; q_valid = 1'b0; q_in = '0; out_ready = 1'b0;
        // Hand-computed results: unsigned sum v_p*2^(7-p); signed negates the MSB plane term.
        vecs[0] = mkv("ones",     1, 1, 1, 1, 1, 1, 1, 1, 20'h000FF, 20'hFFFFF, 0);
        vecs[1] = mkv("max",      4095, 4095, 4095, 4095, 4095, 4095, 4095, 4095, 20'hFEF01, 20'hFF001, 0);
        vecs[2] = mkv("msb_only", 4095, 0, 0, 0, 0, 0, 0, 0, 20'h7FF80, 20'h80080, 0);
        vecs[3] = mkv("lsb_only", 0, 0, 0, 0, 0, 0, 0, 7, 20'h00007, 20'h00007, 0);
        vecs[4] = mkv("one_msb",  1, 0, 0, 0, 0, 0, 0, 0, 20'h00080, 20'hFFF80, 0);
        vecs[5] = mkv("alt",      0, 1, 0, 1, 0, 1, 0, 1, 20'h00055, 20'h00055, 0);
        vecs[6] = mkv("mixed",    3, 2, 1, 0, 0, 0, 0, 5, 20'h00225, 20'hFFF25, 0);
        vecs[7] = mkv("mixed_gap",3, 2, 1, 0, 0, 0, 0, 5, 20'h00225, 20'hFFF25, -1);
        vecs[8] = mkv("max_gap3", 4095, 4095, 4095, 4095, 4095, 4095, 4095, 4095, 20'hFEF01, 20'hFF001, 3);

        @(posedge clk); #1;
        @(posedge clk); #1;
        checkVal("reset q_ready/out_valid/busy", {29'd0, q_ready, out_valid, busy}, 32'b100);
        for (int i = 0; i < LANES; i++) exp_lane[i] = '0;
        checkOutput("reset data");
        rst = 1'b0;

        for (int v = 0; v < 9; v++) begin
            loadUniform(vecs[v]);
            applyStimulus(vecs[v].name, 0, vecs[v].gap);
            drain(vecs[v].name);
        end

        // Distinct per-lane values: lane i = i every plane -> 255*i unsigned, -i signed.
        for (int p = 0; p < NBITS; p++)
            for (int i = 0; i < LANES; i++) cur_planes[p][i] = 12'(i);
        for (int i = 0; i < LANES; i++)
            exp_lane[i] = SIGNED_BUILD ? (20'd0 - 20'(i)) : 20'(255 * i);
        applyStimulus("per_lane", 0, 0);
        drain("per_lane");

        // Back-pressure in HOLD while the producer already offers the next plane.
        loadUniform(vecs[0]);
        applyStimulus("stall", 0, 0);
        q_valid = 1'b1;
        q_in = {LANES{12'd2}};
        for (int c = 0; c < 5; c++) begin
            checkVal("stall q_ready", 32'(q_ready), 32'd0);
            checkVal("stall out_valid", 32'(out_valid), 32'd1);
            checkOutput("stall data stable");
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkVal("stall release idle", {29'd0, q_ready, out_valid, busy}, 32'b100);
        @(posedge clk); #1;
        checkVal("stall held plane accepted", 32'(busy), 32'd1);
        for (int p = 0; p < NBITS; p++)
            for (int i = 0; i < LANES; i++) cur_planes[p][i] = 12'd2;
        for (int i = 0; i < LANES; i++) exp_lane[i] = SIGNED_BUILD ? 20'hFFFFE : 20'd510;
        applyStimulus("after_stall", 1, 0);
        drain("after_stall");

        // Reset in the middle of accumulation drops the partial result.
        loadUniform(vecs[0]);
        q_valid = 1'b1;
        q_in = {LANES{12'd1}};
        repeat (3) begin @(posedge clk); #1; end
        q_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkVal("mid reset state", {29'd0, q_ready, out_valid, busy}, 32'b100);
        for (int c = 0; c < 3; c++) begin
            checkVal("mid reset no out_valid", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end
        loadUniform(vecs[0]);
        applyStimulus("after_reset", 0, 0);
        drain("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
